// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer and the instruction decoder.
// State and error encodings are fixed so debug tooling can decode dbg_state and err_code directly.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LBL_ISSUE = 3'd1,
        ST_LBL_WAIT  = 3'd2,
        ST_EX_ISSUE  = 3'd3,
        ST_EX_WAIT   = 3'd4,
        ST_HALTED    = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_UNDEF_LABEL = 2'd1,
        ERR_PC_WRAP     = 2'd2,
        ERR_DUP_LABEL   = 2'd3
    } err_code_t;

    localparam logic [3:0] OP_STL = 4'b0111;
    localparam logic [3:0] OP_BLT = 4'b1001;
    localparam logic [3:0] OP_HLT = 4'b1110;

    localparam int LBL_ID_W = 4;

    // A run is in progress (an instruction is being presented or awaited).
    function automatic logic is_active(logic [2:0] s);
        return (s == ST_LBL_ISSUE) || (s == ST_LBL_WAIT) ||
               (s == ST_EX_ISSUE)  || (s == ST_EX_WAIT);
    endfunction

    function automatic logic is_label_pass(logic [2:0] s);
        return (s == ST_LBL_ISSUE) || (s == ST_LBL_WAIT);
    endfunction

endpackage

// File: rtl/pc_sequencer_label_table.sv
// Label table: one PC-wide entry plus a valid bit per label id, synchronous write, combinational read.
// Entry data is not reset; the valid bits alone decide whether an entry may be used.
module label_table #(
    parameter int N      = 16,
    parameter int ID_W   = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ID_W-1:0]   wr_id,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ID_W-1:0]   rd_id,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    logic [DATA_W-1:0] entry [N];
    logic [N-1:0]      valid;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_id] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            entry[wr_id] <= wr_data;
        end
    end

    assign rd_data  = entry[rd_id];
    assign rd_valid = valid[rd_id];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and run control: label pass records stl targets, execute pass follows taken blt.
// Handshake: in a *_WAIT state an instruction is accepted on a cycle with dec_valid=1 and stall=0.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          PC_W     = 8,
    parameter int          LBL_N    = 16,
    parameter int unsigned START_PC = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                dec_valid,
    input  logic                label_flag,
    input  logic [LBL_ID_W-1:0] label_id,
    input  logic                branch_flag,
    input  logic                branch_taken,
    input  logic [LBL_ID_W-1:0] branch_id,
    input  logic                halt_flag,
    input  logic                pc_reset_flag,
    output logic [PC_W-1:0]     program_counter,
    output logic                fetch_req,
    output logic                label_pass,
    output logic                running,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code,
    output logic [2:0]          dbg_state
);

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_LBL_ISSUE = ST_LBL_ISSUE;
    localparam logic [2:0] S_LBL_WAIT  = ST_LBL_WAIT;
    localparam logic [2:0] S_EX_ISSUE  = ST_EX_ISSUE;
    localparam logic [2:0] S_EX_WAIT   = ST_EX_WAIT;
    localparam logic [2:0] S_HALTED    = ST_HALTED;

    localparam logic [PC_W-1:0] PC_START = PC_W'(START_PC);
    localparam logic [PC_W-1:0] PC_MAX   = '1;

    logic [2:0]          state, state_nx;
    logic [PC_W-1:0]     pc_nx;
    logic                done_nx, error_nx;
    logic [1:0]          err_nx;
    logic                tbl_clr, tbl_wr;
    logic [LBL_ID_W-1:0] tbl_rd_id;
    logic [PC_W-1:0]     tbl_rd_data;
    logic                tbl_rd_valid;
    logic                accept;
    logic                taken;

    assign accept = dec_valid && !stall;
    assign taken  = branch_flag && branch_taken;

    // One read port serves both the duplicate check (pass 1) and branch lookup (execute).
    assign tbl_rd_id = (state == S_LBL_WAIT) ? label_id : branch_id;

    label_table #(
        .N      (LBL_N),
        .ID_W   (LBL_ID_W),
        .DATA_W (PC_W)
    ) u_label_table (
        .clk      (clk),
        .reset    (reset),
        .clr      (tbl_clr),
        .wr_en    (tbl_wr),
        .wr_id    (label_id),
        .wr_data  (program_counter),
        .rd_id    (tbl_rd_id),
        .rd_data  (tbl_rd_data),
        .rd_valid (tbl_rd_valid)
    );

    always_comb begin
        state_nx = state;
        pc_nx    = program_counter;
        done_nx  = done;
        error_nx = error;
        err_nx   = err_code;
        tbl_clr  = 1'b0;
        tbl_wr   = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_nx = S_LBL_ISSUE;
                    pc_nx    = PC_START;
                    done_nx  = 1'b0;
                    error_nx = 1'b0;
                    err_nx   = ERR_NONE;
                    tbl_clr  = 1'b1;
                end
            end
            S_LBL_ISSUE: state_nx = S_LBL_WAIT;
            S_LBL_WAIT: begin
                if (accept) begin
                    if (label_flag && tbl_rd_valid) begin
                        state_nx = S_HALTED;
                        error_nx = 1'b1;
                        done_nx  = 1'b0;
                        err_nx   = (err_code == ERR_NONE) ? ERR_DUP_LABEL : err_code;
                    end else begin
                        tbl_wr = label_flag;
                        if (pc_reset_flag) begin
                            pc_nx    = PC_START;
                            state_nx = S_EX_ISSUE;
                        end else if (program_counter == PC_MAX) begin
                            state_nx = S_HALTED;
                            error_nx = 1'b1;
                            done_nx  = 1'b0;
                            err_nx   = (err_code == ERR_NONE) ? ERR_PC_WRAP : err_code;
                        end else begin
                            pc_nx    = program_counter + PC_W'(1);
                            state_nx = S_LBL_ISSUE;
                        end
                    end
                end
            end
            S_EX_ISSUE: state_nx = S_EX_WAIT;
            S_EX_WAIT: begin
                if (accept) begin
                    // An undefined taken branch outranks a halt on the same instruction.
                    if (taken && !tbl_rd_valid) begin
                        state_nx = S_HALTED;
                        error_nx = 1'b1;
                        done_nx  = 1'b0;
                        err_nx   = (err_code == ERR_NONE) ? ERR_UNDEF_LABEL : err_code;
                    end else if (halt_flag) begin
                        state_nx = S_HALTED;
                        done_nx  = 1'b1;
                    end else if (taken) begin
                        pc_nx    = tbl_rd_data;
                        state_nx = S_EX_ISSUE;
                    end else if (program_counter == PC_MAX) begin
                        state_nx = S_HALTED;
                        error_nx = 1'b1;
                        done_nx  = 1'b0;
                        err_nx   = (err_code == ERR_NONE) ? ERR_PC_WRAP : err_code;
                    end else begin
                        pc_nx    = program_counter + PC_W'(1);
                        state_nx = S_EX_ISSUE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Status outputs are flopped from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            program_counter <= PC_START;
            done            <= 1'b0;
            error           <= 1'b0;
            err_code        <= ERR_NONE;
            fetch_req       <= 1'b0;
            label_pass      <= 1'b0;
            running         <= 1'b0;
        end else begin
            state           <= state_nx;
            program_counter <= pc_nx;
            done            <= done_nx;
            error           <= error_nx;
            err_code        <= err_nx;
            fetch_req       <= is_active(state_nx);
            label_pass      <= is_label_pass(state_nx);
            running         <= is_active(state_nx);
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: acts as instruction memory plus decoder for small programs and checks
// every presented PC against a program interpreter that walks both passes.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam logic [1:0] K_NOP = 2'd0;
    localparam logic [1:0] K_STL = 2'd1;
    localparam logic [1:0] K_BLT = 2'd2;
    localparam logic [1:0] K_HLT = 2'd3;

    logic       clk = 1'b0;
    logic       reset, start, stall, dec_valid;
    logic       label_flag, branch_flag, branch_taken, halt_flag, pc_reset_flag;
    logic [3:0] label_id, branch_id;
    logic [7:0] program_counter;
    logic       fetch_req, label_pass, running, done, error;
    logic [1:0] err_code;
    logic [2:0] dbg_state;

    pc_sequencer #(.PC_W(8), .LBL_N(16), .START_PC(0)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stall           (stall),
        .dec_valid       (dec_valid),
        .label_flag      (label_flag),
        .label_id        (label_id),
        .branch_flag     (branch_flag),
        .branch_taken    (branch_taken),
        .branch_id       (branch_id),
        .halt_flag       (halt_flag),
        .pc_reset_flag   (pc_reset_flag),
        .program_counter (program_counter),
        .fetch_req       (fetch_req),
        .label_pass      (label_pass),
        .running         (running),
        .done            (done),
        .error           (error),
        .err_code        (err_code),
        .dbg_state       (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // program image and scoreboard
    logic [1:0] kind [256];
    logic [3:0] idv  [256];
    logic       tkv  [256];
    logic [8:0] exp_q [$];   // {label_pass, pc} of each instruction in acceptance order
    logic       exp_done;
    logic [1:0] exp_err;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            kind[i] = K_NOP;
            idv[i]  = 4'd0;
            tkv[i]  = 1'b0;
        end
    endtask

    task automatic put(input int pc, input logic [1:0] k, input int id, input bit tk);
        kind[pc] = k;
        idv[pc]  = 4'(id);
        tkv[pc]  = tk;
    endtask

    // Interpreter: label pass to the first hlt, then execute from 0.
    task automatic build_expect(output bit ok);
        logic [7:0] tbl [16];
        bit         vld [16];
        int         pc;
        int         steps;
        for (int i = 0; i < 16; i++) begin
            vld[i] = 1'b0;
            tbl[i] = 8'd0;
        end
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 2'd0;
        ok       = 1'b1;
        pc       = 0;
        while (1) begin
            exp_q.push_back({1'b1, 8'(pc)});
            if (kind[pc] == K_STL) begin
                if (vld[idv[pc]]) begin exp_err = 2'd3; return; end
                vld[idv[pc]] = 1'b1;
                tbl[idv[pc]] = 8'(pc);
            end
            if (kind[pc] == K_HLT) break;
            if (pc == 255) begin exp_err = 2'd2; return; end
            pc++;
        end
        pc    = 0;
        steps = 0;
        while (steps < 2000) begin
            steps++;
            exp_q.push_back({1'b0, 8'(pc)});
            if (kind[pc] == K_HLT) begin exp_done = 1'b1; return; end
            if (kind[pc] == K_BLT && tkv[pc]) begin
                if (!vld[idv[pc]]) begin exp_err = 2'd1; return; end
                pc = int'(tbl[idv[pc]]);
            end else if (pc == 255) begin
                exp_err = 2'd2;
                return;
            end else begin
                pc++;
            end
        end
        ok = 1'b0;
    endtask

    // driver tasks
    task automatic idle_inputs();
        start = 0; stall = 0; dec_valid = 0;
        label_flag = 0; label_id = 0; branch_flag = 0; branch_taken = 0;
        branch_id = 0; halt_flag = 0; pc_reset_flag = 0;
    endtask

    task automatic drive_decode(input logic [7:0] pc, input logic lp);
        label_flag    = (kind[pc] == K_STL);
        label_id      = idv[pc];
        branch_flag   = (kind[pc] == K_BLT);
        branch_taken  = tkv[pc];
        branch_id     = idv[pc];
        halt_flag     = (kind[pc] == K_HLT) && !lp;
        pc_reset_flag = (kind[pc] == K_HLT) && lp;
    endtask

    task automatic drive_noise();
        dec_valid     = 1'($urandom_range(0, 1));
        stall         = 1'($urandom_range(0, 1));
        label_flag    = 1'($urandom_range(0, 1));
        label_id      = 4'($urandom_range(0, 15));
        branch_flag   = 1'($urandom_range(0, 1));
        branch_taken  = 1'($urandom_range(0, 1));
        branch_id     = 4'($urandom_range(0, 15));
        halt_flag     = 1'($urandom_range(0, 1));
        pc_reset_flag = 1'($urandom_range(0, 1));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ":state"}, 32'(dbg_state), 32'(ST_IDLE));
        check_eq({tag, ":pc"}, 32'(program_counter), 0);
        check_eq({tag, ":flags"}, {27'd0, fetch_req, label_pass, running, done, error}, 0);
        check_eq({tag, ":err_code"}, 32'(err_code), 0);
    endtask

    // Runs the loaded program; abort_pc >= 0 asserts reset (with start) when execute reaches it.
    task automatic run_prog(input string name, input int abort_pc);
        bit         ok;
        bit         phase;
        bit         dv, st;
        int         cyc;
        int         stall_left;
        logic [8:0] head, last;
        logic [2:0] exp_st;
        build_expect(ok);
        if (!ok) return;
        last = exp_q[$];
        idle_inputs();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check_eq({name, ":start_clr"}, {29'd0, done, error, running}, 1);
        phase = 0; cyc = 0; stall_left = 0;
        while (exp_q.size() > 0) begin
            if (cyc > 6000) begin
                check_eq({name, ":timeout_pending"}, exp_q.size(), 0);
                exp_q.delete();
                break;
            end
            head = exp_q[0];
            if (abort_pc >= 0 && !phase && head == {1'b0, 8'(abort_pc)}) begin
                idle_inputs();
                reset = 1; start = 1;
                @(posedge clk); #1;
                reset = 0; start = 0;
                check_idle({name, ":reset_mid_run"});
                exp_q.delete();
                return;
            end
            exp_st = phase ? (head[8] ? ST_LBL_WAIT : ST_EX_WAIT)
                           : (head[8] ? ST_LBL_ISSUE : ST_EX_ISSUE);
            check_eq({name, ":pc"}, 32'(program_counter), 32'(head[7:0]));
            check_eq({name, ":label_pass"}, 32'(label_pass), 32'(head[8]));
            check_eq({name, ":state"}, 32'(dbg_state), 32'(exp_st));
            check_eq({name, ":fetch_run"}, {30'd0, fetch_req, running}, 3);
            idle_inputs();
            start = ($urandom_range(0, 15) == 0);
            if (!phase) begin
                drive_noise();
                phase = 1;
            end else begin
                if (stall_left == 0 && $urandom_range(0, 3) == 0) stall_left = $urandom_range(1, 3);
                if (stall_left > 0) begin
                    st = 1; dv = 1; stall_left--;
                end else begin
                    st = 0; dv = ($urandom_range(0, 3) != 0);
                end
                drive_decode(program_counter, label_pass);
                dec_valid = dv;
                stall     = st;
                if (dv && !st) begin
                    void'(exp_q.pop_front());
                    phase = 0;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        idle_inputs();
        check_eq({name, ":end_state"}, 32'(dbg_state), 32'(ST_HALTED));
        check_eq({name, ":end_flags"}, {29'd0, fetch_req, label_pass, running}, 0);
        check_eq({name, ":done"}, 32'(done), 32'(exp_done));
        check_eq({name, ":error"}, 32'(error), 32'(exp_err != 2'd0));
        check_eq({name, ":err_code"}, 32'(err_code), 32'(exp_err));
        check_eq({name, ":end_pc"}, 32'(program_counter), 32'(last[7:0]));
        drive_noise();
        @(posedge clk); #1;
        idle_inputs();
        check_eq({name, ":halt_hold_pc"}, 32'(program_counter), 32'(last[7:0]));
        check_eq({name, ":halt_hold_state"}, 32'(dbg_state), 32'(ST_HALTED));
    endtask

    task automatic load_label_example(input int blt_id, input bit tk);
        clear_prog();
        put(2, K_STL, 3, 0);
        put(4, K_BLT, blt_id, tk);
        put(6, K_STL, 5, 0);
        put(9, K_HLT, 0, 0);
    endtask

    task automatic gen_random();
        int len;
        int r;
        clear_prog();
        len = $urandom_range(6, 40);
        for (int i = 0; i < len - 1; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      put(i, K_NOP, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            else if (r < 7) put(i, K_STL, $urandom_range(0, 15), 0);
            else            put(i, K_BLT, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end
        put(len - 1, K_HLT, 0, 0);
    endtask

    initial begin
        bit ok;
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 0;
        @(posedge clk); #1;
        check_idle("idle_hold");

        load_label_example(5, 1);
        run_prog("blt_taken", -1);
        load_label_example(5, 0);
        run_prog("blt_not_taken", -1);
        load_label_example(7, 1);
        run_prog("undef_label", -1);

        clear_prog();
        put(1, K_STL, 4, 0);
        put(3, K_STL, 4, 0);
        put(5, K_HLT, 0, 0);
        run_prog("dup_label", -1);

        clear_prog();
        run_prog("pc_wrap", -1);

        load_label_example(5, 1);
        run_prog("reset_mid_exec", 7);

        clear_prog();
        put(1, K_BLT, 5, 1);
        put(3, K_HLT, 0, 0);
        run_prog("table_cleared", -1);

        for (int n = 0; n < 40; n++) begin
            ok = 0;
            for (int t = 0; t < 20 && !ok; t++) begin
                gen_random();
                build_expect(ok);
            end
            if (ok) run_prog($sformatf("rand%0d", n), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
